uart_decoder: RTL and testbench
===============================

// Module: uart_decoder
// PURPOSE
// - Receive-side counterpart of the player-state UART transmitter; pops bytes from the UART RX FIFO.
// - Byte format: {payload[4:0], tag[2:0]}. It rebuilds the remote player's frame from six tagged bytes.
// - Publishes x, y, player id and collision atomically, once per complete frame, to game logic (remote player draw/ctl).
// PARAMETERS
// - TIMEOUT_CYCLES  6_500_000  idle cycles (100 ms @65 MHz) before a partial frame is abandoned (FRAME_TIMEOUT_EN only)
// PORTS
// - clk               in   1  system clock; single clock domain
// - rst               in   1  synchronous, active-high reset
// - rx_empty          in   1  RX FIFO empty flag
// - r_data            in   8  RX FIFO head byte (show-ahead; valid while !rx_empty)
// - rd_uart           out  1  RX FIFO pop strobe; registered; one-cycle pulse
// - remote_player     out  2  player id from the last good frame (2'b01 or 2'b11)
// - remote_x          out  8  remote x position
// - remote_y          out  8  remote y position
// - remote_collision  out  1  remote collision flag
// - frame_valid       out  1  one-cycle pulse, in the same cycle the remote_* outputs update
// - frame_error       out  1  one-cycle pulse on a sequence or format violation
// BEHAVIOUR
// - Reset: rd_uart=0, frame_valid=0, frame_error=0, remote_*=0, FSM=HUNT, shadow regs=0, timeout ctr=0.
// - Pop handshake:
//   - Cycle N: !rx_empty && !rd_uart -> rd_uart=1 in N+1.
//   - Cycle N+1: r_data is decoded; the FIFO pops at the end of N+1.
//   - rd_uart is never high two cycles in a row; max throughput is 1 byte per 2 clk.
// - Byte fields (decoded only when rd_uart=1):
//   - tag = r_data[2:0]; nibble = r_data[6:3].
//   - Data bytes require r_data[7]=0, else error.
// - Tag map:
//   - 000 header: r_data[7:5]=0; player = r_data[4:3].
//   - 001 x[3:0]; 010 x[7:4].
//   - 011 y[7:4]; 100 y[3:0].
//   - 101 collision: collision = r_data[3]; r_data[7:4] must be 0.
// - FSM states: HUNT, HDR, XL, XH, YH, YL (state = last tag accepted).
//   - HUNT: only a valid header is accepted (-> HDR). All other bytes are dropped silently, with no error.
//   - Valid header: player in {01,11}. A header with player 00/10 stays in HUNT and pulses frame_error.
//   - Expected successor of each state: HDR->001, XL->010, XH->011, YH->100, YL->101.
//   - Correct next tag: store the field into shadow regs and advance.
//   - Same tag as the current state (transmitter repeat): overwrite the shadow field, stay, no error.
//   - Tag 101 in state YL: commit shadow -> remote_*, pulse frame_valid, -> HUNT.
//     - Outputs are visible the cycle after the pop cycle.
//   - Valid header in any non-HUNT state: pulse frame_error, restart at HDR with the new player id. The partial frame is discarded.
//   - Any other tag, or a format violation (bit7 set, nonzero pad bits): pulse frame_error, -> HUNT.
//   - Tags 110/111 are always invalid: error if not in HUNT, ignored in HUNT.
// - Trailing repeats of 101 after a commit arrive in HUNT and are dropped.
// - remote_* are held between commits; partial frames never alter them.
// - rst mid-frame: the shadow frame is discarded and all outputs return to reset values next cycle.
// CONFIGURATION
// - `define FRAME_TIMEOUT_EN:
//   - The timeout counter clears on every pop and increments while the FSM is not in HUNT.
//   - On reaching TIMEOUT_CYCLES-1: -> HUNT, pulse frame_error, counter cleared.
//   - Without the macro: no counter logic; a partial frame waits indefinitely.
// STRUCTURE
// - game_pkg:
//   - localparams UART_TAG_HDR=3'd0, UART_TAG_XL=3'd1, UART_TAG_XH=3'd2, UART_TAG_YH=3'd3, UART_TAG_YL=3'd4, UART_TAG_COL=3'd5.
//   - typedef enum logic [2:0] uart_rx_state_t {HUNT,HDR,XL,XH,YH,YL}.
//   - PLAYER_1=2'b01, PLAYER_2=2'b11.
// - Sub-module uart_rx_watchdog (counter + expiry pulse); instantiated only under FRAME_TIMEOUT_EN.
// TESTING
// - Frame 08,29,52,1B,64,0D via FIFO model:
//   - one frame_valid; remote_player=01, x=A5, y=3C, collision=1.
//   - rd_uart never high on consecutive cycles.
// - Same frame with every byte sent twice -> identical result, exactly one frame_valid, no frame_error.
// - 08,29,1B:
//   - 1B pulses frame_error, no frame_valid, remote_* unchanged.
//   - A following full player-11 frame (18,...) commits normally.
// - 08,29,52 then header 18 then rest of player-11 frame:
//   - one frame_error at 18, then a commit with remote_player=11.
// - Pre-reset frame commits, then rst asserted mid-frame (after 52):
//   - next cycle all outputs 0; the resumed bytes 1B,64,0D are dropped in HUNT.
// - FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=16:
//   - 08,29 then idle 16 cycles -> frame_error, FSM HUNT.
//   - A late 52 is dropped silently.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the player-state UART link.
package game_pkg;

    localparam logic [2:0] UART_TAG_HDR = 3'd0;
    localparam logic [2:0] UART_TAG_XL  = 3'd1;
    localparam logic [2:0] UART_TAG_XH  = 3'd2;
    localparam logic [2:0] UART_TAG_YH  = 3'd3;
    localparam logic [2:0] UART_TAG_YL  = 3'd4;
    localparam logic [2:0] UART_TAG_COL = 3'd5;

    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b11;

    typedef enum logic [2:0] {HUNT, HDR, XL, XH, YH, YL} uart_rx_state_t;

    // Tag of the byte that brought the FSM into a state (HUNT has none; HDR tag is harmless there).
    function automatic logic [2:0] state_tag(input uart_rx_state_t s);
        case (s)
            XL:      state_tag = UART_TAG_XL;
            XH:      state_tag = UART_TAG_XH;
            YH:      state_tag = UART_TAG_YH;
            YL:      state_tag = UART_TAG_YL;
            default: state_tag = UART_TAG_HDR;
        endcase
    endfunction

    function automatic logic [2:0] next_tag(input uart_rx_state_t s);
        case (s)
            HDR:     next_tag = UART_TAG_XL;
            XL:      next_tag = UART_TAG_XH;
            XH:      next_tag = UART_TAG_YH;
            YH:      next_tag = UART_TAG_YL;
            YL:      next_tag = UART_TAG_COL;
            default: next_tag = UART_TAG_HDR;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_watchdog.sv
// Idle watchdog for partially received frames; used only when FRAME_TIMEOUT_EN is defined.
module uart_rx_watchdog #(
    parameter int TIMEOUT_CYCLES = 6_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = active && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || !active || expired)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_decoder.sv
// Rebuilds remote player frames from tagged UART bytes popped from the RX FIFO.
// Optional idle timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_decoder
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 6_500_000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic [1:0] remote_player,
    output logic [7:0] remote_x,
    output logic [7:0] remote_y,
    output logic       remote_collision,
    output logic       frame_valid,
    output logic       frame_error
);

    uart_rx_state_t state, state_next;
    logic [1:0] shadow_player, player_next;
    logic [7:0] shadow_x, x_next, shadow_y, y_next;
    logic       shadow_col, col_next;
    logic       commit, error;

    logic [2:0] tag;
    logic [3:0] nibble;
    logic       player_ok, hdr_ok, field_ok;

    assign tag       = r_data[2:0];
    assign nibble    = r_data[6:3];
    assign player_ok = (r_data[4:3] == PLAYER_1) || (r_data[4:3] == PLAYER_2);
    assign hdr_ok    = (tag == UART_TAG_HDR) && (r_data[7:5] == 3'b000) && player_ok;

    // Format check of the current byte according to its tag.
    always_comb begin
        case (tag)
            UART_TAG_HDR: field_ok = hdr_ok;
            UART_TAG_COL: field_ok = (r_data[7:4] == 4'b0000);
            default:      field_ok = !r_data[7];
        endcase
    end

`ifdef FRAME_TIMEOUT_EN
    logic timeout;

    uart_rx_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (rd_uart),
        .active  (state != HUNT),
        .expired (timeout)
    );
`endif

    // Byte decode happens only in the pop cycle; a repeat of the current tag simply overwrites its field.
    always_comb begin
        state_next  = state;
        player_next = shadow_player;
        x_next      = shadow_x;
        y_next      = shadow_y;
        col_next    = shadow_col;
        commit      = 1'b0;
        error       = 1'b0;
        if (rd_uart) begin
            if (state == HUNT) begin
                if (tag == UART_TAG_HDR && r_data[7:5] == 3'b000) begin
                    if (player_ok) begin
                        state_next  = HDR;
                        player_next = r_data[4:3];
                    end else begin
                        error = 1'b1;
                    end
                end
            end else if (tag == state_tag(state) || tag == next_tag(state)) begin
                if (!field_ok) begin
                    error      = 1'b1;
                    state_next = HUNT;
                end else begin
                    case (tag)
                        UART_TAG_HDR: begin
                            player_next = r_data[4:3];
                            state_next  = HDR;
                        end
                        UART_TAG_XL: begin
                            x_next[3:0] = nibble;
                            state_next  = XL;
                        end
                        UART_TAG_XH: begin
                            x_next[7:4] = nibble;
                            state_next  = XH;
                        end
                        UART_TAG_YH: begin
                            y_next[7:4] = nibble;
                            state_next  = YH;
                        end
                        UART_TAG_YL: begin
                            y_next[3:0] = nibble;
                            state_next  = YL;
                        end
                        default: begin
                            col_next   = r_data[3];
                            commit     = 1'b1;
                            state_next = HUNT;
                        end
                    endcase
                end
            end else if (hdr_ok) begin
                error       = 1'b1;
                state_next  = HDR;
                player_next = r_data[4:3];
                x_next      = '0;
                y_next      = '0;
                col_next    = 1'b0;
            end else begin
                error      = 1'b1;
                state_next = HUNT;
            end
        end
`ifdef FRAME_TIMEOUT_EN
        else if (timeout) begin
            error      = 1'b1;
            state_next = HUNT;
        end
`endif
    end

    // State, pop strobe, shadow registers and atomically committed outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= HUNT;
            rd_uart          <= 1'b0;
            shadow_player    <= '0;
            shadow_x         <= '0;
            shadow_y         <= '0;
            shadow_col       <= 1'b0;
            remote_player    <= '0;
            remote_x         <= '0;
            remote_y         <= '0;
            remote_collision <= 1'b0;
            frame_valid      <= 1'b0;
            frame_error      <= 1'b0;
        end else begin
            state         <= state_next;
            rd_uart       <= !rx_empty && !rd_uart;
            shadow_player <= player_next;
            shadow_x      <= x_next;
            shadow_y      <= y_next;
            shadow_col    <= col_next;
            frame_valid   <= commit;
            frame_error   <= error;
            if (commit) begin
                remote_player    <= player_next;
                remote_x         <= x_next;
                remote_y         <= y_next;
                remote_collision <= col_next;
            end
        end
    end

endmodule

// File: tb/tb_uart_decoder.sv
// Self-checking bench for uart_decoder: FIFO model feeding bytes, scoreboard of expected frames.
module tb_uart_decoder;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic [1:0] remote_player;
    logic [7:0] remote_x, remote_y;
    logic       remote_collision, frame_valid, frame_error;

    typedef struct {
        logic [1:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
    } frame_t;

    logic [7:0] fifo[$];
    frame_t     exp_q[$];
    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int valid_seen = 0;
    int rd_b2b = 0;
    logic rd_prev = 1'b0;
    logic pop_pending = 1'b0;

    uart_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_empty         (rx_empty),
        .r_data           (r_data),
        .rd_uart          (rd_uart),
        .remote_player    (remote_player),
        .remote_x         (remote_x),
        .remote_y         (remote_y),
        .remote_collision (remote_collision),
        .frame_valid      (frame_valid),
        .frame_error      (frame_error)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO: a pop requested during a cycle takes effect just after the closing edge.
    always begin
        @(negedge clk);
        pop_pending = rd_uart;
        @(posedge clk);
        #1;
        if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
        rx_empty = (fifo.size() == 0);
        r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Monitor: counts pulses, detects back-to-back pops, and scores committed frames.
    always @(negedge clk) begin
        frame_t e;
        if (rd_uart && rd_prev) rd_b2b++;
        rd_prev = rd_uart;
        if (frame_error) err_seen++;
        if (frame_valid) begin
            valid_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL frame_unexpected got p=%h x=%h y=%h c=%b required no frame",
                         remote_player, remote_x, remote_y, remote_collision);
            end else begin
                e = exp_q.pop_front();
                if ({remote_player, remote_x, remote_y, remote_collision} !== {e.p, e.x, e.y, e.c}) begin
                    failures++;
                    $display("[TB] FAIL frame_fields got p=%h x=%h y=%h c=%b required p=%h x=%h y=%h c=%b",
                             remote_player, remote_x, remote_y, remote_collision, e.p, e.x, e.y, e.c);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout got running required finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    // Independent encoder of the transmitter byte format.
    task automatic send_frame(input logic [1:0] p, input logic [7:0] x, input logic [7:0] y,
                              input logic c, input int reps);
        logic [7:0] bytes [6];
        bytes[0] = {3'b000, p, 3'd0};
        bytes[1] = {1'b0, x[3:0], 3'd1};
        bytes[2] = {1'b0, x[7:4], 3'd2};
        bytes[3] = {1'b0, y[7:4], 3'd3};
        bytes[4] = {1'b0, y[3:0], 3'd4};
        bytes[5] = {4'b0000, c, 3'd5};
        for (int i = 0; i < 6; i++)
            for (int r = 0; r < reps; r++) send(bytes[i]);
    endtask

    task automatic expect_frame(input logic [1:0] p, input logic [7:0] x, input logic [7:0] y,
                                input logic c);
        frame_t f;
        f.p = p; f.x = x; f.y = y; f.c = c;
        exp_q.push_back(f);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(fifo.size() == 0 && rx_empty && !rd_uart) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout got %0d bytes left required 0", fifo.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_uart, frame_valid, frame_error, remote_player, remote_x, remote_y, remote_collision} !== 22'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got rd=%b v=%b e=%b p=%h x=%h y=%h c=%b required all 0",
                     rd_uart, frame_valid, frame_error, remote_player, remote_x, remote_y, remote_collision);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int v0 = valid_seen, e0 = err_seen;
        logic [7:0] tbl [6] = '{8'h08, 8'h29, 8'h52, 8'h1B, 8'h64, 8'h0D};
        expect_frame(2'b01, 8'hA5, 8'h3C, 1'b1);
        for (int i = 0; i < 6; i++) send(tbl[i]);
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 1 || err_seen - e0 !== 0) begin
            failures++;
            $display("[TB] FAIL basic_counts got valid=%0d err=%0d required valid=1 err=0",
                     valid_seen - v0, err_seen - e0);
        end
        checks++;
        if (rd_b2b !== 0) begin
            failures++;
            $display("[TB] FAIL rd_back_to_back got %0d required 0", rd_b2b);
        end
    endtask

    task automatic test_repeats();
        int v0 = valid_seen, e0 = err_seen;
        logic [7:0] tbl [6] = '{8'h08, 8'h29, 8'h52, 8'h1B, 8'h64, 8'h0D};
        expect_frame(2'b01, 8'hA5, 8'h3C, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send(tbl[i]);
            send(tbl[i]);
        end
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 1 || err_seen - e0 !== 0) begin
            failures++;
            $display("[TB] FAIL repeat_counts got valid=%0d err=%0d required valid=1 err=0",
                     valid_seen - v0, err_seen - e0);
        end
    endtask

    task automatic test_bad_sequence();
        int v0 = valid_seen, e0 = err_seen;
        send(8'h08); send(8'h29); send(8'h1B);
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 0 || err_seen - e0 !== 1) begin
            failures++;
            $display("[TB] FAIL badseq_counts got valid=%0d err=%0d required valid=0 err=1",
                     valid_seen - v0, err_seen - e0);
        end
        checks++;
        if ({remote_player, remote_x, remote_y, remote_collision} !== {2'b01, 8'hA5, 8'h3C, 1'b1}) begin
            failures++;
            $display("[TB] FAIL badseq_hold got p=%h x=%h y=%h c=%b required p=1 x=a5 y=3c c=1",
                     remote_player, remote_x, remote_y, remote_collision);
        end
        expect_frame(2'b11, 8'h5A, 8'hC3, 1'b0);
        send_frame(2'b11, 8'h5A, 8'hC3, 1'b0, 1);
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 1) begin
            failures++;
            $display("[TB] FAIL badseq_recover got valid=%0d required 1", valid_seen - v0);
        end
    endtask

    task automatic test_header_restart();
        int v0 = valid_seen, e0 = err_seen;
        logic [7:0] tbl [9] = '{8'h08, 8'h29, 8'h52, 8'h18, 8'h29, 8'h52, 8'h1B, 8'h64, 8'h0D};
        expect_frame(2'b11, 8'hA5, 8'h3C, 1'b1);
        for (int i = 0; i < 9; i++) send(tbl[i]);
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 1 || err_seen - e0 !== 1) begin
            failures++;
            $display("[TB] FAIL restart_counts got valid=%0d err=%0d required valid=1 err=1",
                     valid_seen - v0, err_seen - e0);
        end
    endtask

    task automatic test_format_errors();
        int v0 = valid_seen, e0 = err_seen;
        logic [7:0] tbl [18] = '{8'h00, 8'h10, 8'h0E, 8'h0F, 8'h29, 8'h28,
                                 8'h08, 8'hA9,
                                 8'h08, 8'h29, 8'h52, 8'h1B, 8'h64, 8'h1D,
                                 8'h08, 8'h0E,
                                 8'h0D, 8'h0D};
        for (int i = 0; i < 18; i++) send(tbl[i]);
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 0 || err_seen - e0 !== 5) begin
            failures++;
            $display("[TB] FAIL format_counts got valid=%0d err=%0d required valid=0 err=5",
                     valid_seen - v0, err_seen - e0);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_seen, e0 = err_seen;
        logic [7:0] x, y;
        logic c;
        for (int i = 0; i < 4; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            expect_frame((i % 2 == 0) ? PLAYER_1 : PLAYER_2, x, y, c);
            send_frame((i % 2 == 0) ? PLAYER_1 : PLAYER_2, x, y, c, 1 + i % 2);
        end
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 4 || err_seen - e0 !== 0 || exp_q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_counts got valid=%0d err=%0d pending=%0d required 4 0 0",
                     valid_seen - v0, err_seen - e0, exp_q.size());
        end
        checks++;
        if (rd_b2b !== 0) begin
            failures++;
            $display("[TB] FAIL rd_back_to_back got %0d required 0", rd_b2b);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        expect_frame(2'b01, 8'hA5, 8'h3C, 1'b1);
        send_frame(2'b01, 8'hA5, 8'h3C, 1'b1, 1);
        send(8'h08); send(8'h29); send(8'h52);
        wait_drain();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rd_uart, frame_valid, frame_error, remote_player, remote_x, remote_y, remote_collision} !== 22'd0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got p=%h x=%h y=%h c=%b required all 0",
                     remote_player, remote_x, remote_y, remote_collision);
        end
        v0 = valid_seen;
        e0 = err_seen;
        send(8'h1B); send(8'h64); send(8'h0D);
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 0 || err_seen - e0 !== 0 || remote_x !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_resume got valid=%0d err=%0d x=%h required 0 0 00",
                     valid_seen - v0, err_seen - e0, remote_x);
        end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int v0 = valid_seen, e0 = err_seen;
        int n = 0;
        send(8'h08); send(8'h29);
        while (err_seen == e0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (err_seen - e0 !== 1) begin
            failures++;
            $display("[TB] FAIL timeout_error got %0d required 1", err_seen - e0);
        end
        send(8'h52);
        wait_drain();
        checks++;
        if (valid_seen - v0 !== 0 || err_seen - e0 !== 1) begin
            failures++;
            $display("[TB] FAIL timeout_late got valid=%0d err=%0d required 0 1",
                     valid_seen - v0, err_seen - e0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_repeats();
        test_bad_sequence();
        test_header_restart();
        test_format_errors();
        test_back_to_back();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_leftover got %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
